// File: rtl/dmem_responder_pkg.sv
// Shared datapath package for the data-memory responder:
// FSM encoding, size/latency defaults and the address-error rule.
package dmem_responder_pkg;

  localparam int DEPTH_DEF   = 64;
  localparam int LATENCY_DEF = 2;
  localparam int CNT_W       = 4;

  localparam logic [1:0] ALIGN_OK  = 2'b00;
  localparam int         WORD_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic addrErr(
    input logic [31:0] addr,
    input int          depth
  );
    return (addr[1:0] != ALIGN_OK) ||
           (addr >= 32'(WORD_BYTES * depth));
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage: sync write, comb read, cleared by reset.
// Ports: clk, rst_n, we, addr (word index), wdata, rdata.
module dmem_array
  import dmem_responder_pkg::*;
#(
  parameter  int DEPTH = DEPTH_DEF,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency load/store responder for the MEM stage.
// Ports: req_* handshake in, rsp_* handshake out, clk/rst_n.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH   = DEPTH_DEF,
  parameter int LATENCY = LATENCY_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_INIT =
    CNT_W'(LATENCY - 1);

  state_t           state;
  state_t           nextState;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      capAddr;
  logic [31:0]      capWdata;
  logic             capWrite;
  logic [31:0]      rdataQ;
  logic             errQ;
  logic [31:0]      memRdata;
  logic             accept;
  logic             enterResp;
  logic             capErr;
  logic             memWe;

  assign accept    = (state == IDLE) && req_valid;
  // Counter reaching zero in BUSY marks edge LATENCY.
  assign enterResp = (state == BUSY) && (cnt == '0);
  assign capErr    = addrErr(capAddr, DEPTH);
  assign memWe     = enterResp && capWrite && !capErr;

  dmem_array #(.DEPTH(DEPTH)) u_array (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (memWe),
    .addr  (capAddr[AW+1:2]),
    .wdata (capWdata),
    .rdata (memRdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE: if (req_valid) nextState = BUSY;
      BUSY: if (cnt == '0) nextState = RESP;
      RESP: if (rsp_ready) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    unique case (1'b1)
      (state == IDLE): req_ready = 1'b1;
      (state == RESP): rsp_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      capAddr  <= '0;
      capWdata <= '0;
      capWrite <= 1'b0;
      rdataQ   <= '0;
      errQ     <= 1'b0;
    end else begin
      if (accept) begin
        cnt      <= CNT_INIT;
        capAddr  <= req_addr;
        capWdata <= req_wdata;
        capWrite <= req_write;
      end else if (state == BUSY && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (enterResp) begin
        rdataQ <= (capErr || capWrite) ? '0 : memRdata;
        errQ   <= capErr;
      end
    end
  end

  assign rsp_rdata = rdataQ;
  assign rsp_err   = errQ;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder against a word-array model.
// Also measures response latency on LATENCY=1 and 15 builds.
module tb_dmem_responder;

  localparam int LAT   = 2;
  localparam int DEPTH = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        reqValid, reqWrite, rspReady;
  logic [31:0] reqAddr, reqWdata;
  logic        reqReady, rspValid, rspErr;
  logic [31:0] rspRdata;

  logic        rv1, rr1, rdy1, vld1, err1;
  logic [31:0] rd1;
  logic        rv15, rr15, rdy15, vld15, err15;
  logic [31:0] rd15;

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(reqValid), .req_ready(reqReady),
    .req_write(reqWrite), .req_addr(reqAddr),
    .req_wdata(reqWdata),
    .rsp_valid(rspValid), .rsp_ready(rspReady),
    .rsp_rdata(rspRdata), .rsp_err(rspErr)
  );

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(1)) u_l1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(rv1), .req_ready(rdy1),
    .req_write(1'b0), .req_addr(32'h4),
    .req_wdata(32'h0),
    .rsp_valid(vld1), .rsp_ready(rr1),
    .rsp_rdata(rd1), .rsp_err(err1)
  );

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(15)) u_l15 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(rv15), .req_ready(rdy15),
    .req_write(1'b0), .req_addr(32'h8),
    .req_wdata(32'h0),
    .rsp_valid(vld15), .rsp_ready(rr15),
    .rsp_rdata(rd15), .rsp_err(err15)
  );

  int nTests = 0;
  int nFail  = 0;
  logic [31:0] refMem [DEPTH];

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h",
               tag, got, exp);
    end
  endtask

  task automatic clearModel();
    for (int i = 0; i < DEPTH; i++) refMem[i] = '0;
  endtask

  // One request; hold = cycles of rsp_ready low in RESP.
  task automatic doReq(
    input logic        wr,
    input logic [31:0] addr,
    input logic [31:0] wd,
    input int          hold
  );
    logic        expErr;
    logic [31:0] expData;
    int          n;
    expErr  = (addr % 4 != 0) || (addr >= 4 * DEPTH);
    expData = 32'h0;
    if (!expErr && !wr) expData = refMem[addr / 4];
    if (!expErr && wr) refMem[addr / 4] = wd;

    @(negedge clk);
    check("ready_idle", 32'(reqReady), 32'd1);
    reqValid = 1'b1;
    reqWrite = wr;
    reqAddr  = addr;
    reqWdata = wd;
    rspReady = 1'($urandom_range(0, 1));
    @(posedge clk);
    #1;
    reqValid = 1'($urandom_range(0, 1));
    reqWrite = ~wr;
    reqAddr  = $urandom;
    reqWdata = $urandom;
    check("ready_busy", 32'(reqReady), 32'd0);
    n = 0;
    while (!rspValid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("latency", 32'(n), 32'(LAT));
    rspReady = (hold == 0);
    for (int c = 0; c <= hold; c++) begin
      if (c > 0) begin
        @(posedge clk);
        #1;
        if (c == hold) rspReady = 1'b1;
      end
      reqValid = 1'b1;
      check("rsp_valid", 32'(rspValid), 32'd1);
      check("rdata", rspRdata, expData);
      check("err", 32'(rspErr), 32'(expErr));
      check("ready_resp", 32'(reqReady), 32'd0);
    end
    @(posedge clk);
    #1;
    reqValid = 1'b0;
    rspReady = 1'b0;
    check("rsp_drop", 32'(rspValid), 32'd0);
    check("idle_after", 32'(reqReady), 32'd1);
  endtask

  task automatic measure1();
    int n;
    @(negedge clk);
    rv1 = 1'b1;
    @(posedge clk);
    #1;
    rv1 = 1'b0;
    n = 0;
    while (!vld1 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("lat1", 32'(n), 32'd1);
    check("lat1_data", rd1, 32'h0);
    rr1 = 1'b1;
    @(posedge clk);
    #1;
    rr1 = 1'b0;
  endtask

  task automatic measure15();
    int n;
    @(negedge clk);
    rv15 = 1'b1;
    @(posedge clk);
    #1;
    rv15 = 1'b0;
    n = 0;
    while (!vld15 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("lat15", 32'(n), 32'd15);
    check("lat15_err", 32'(err15), 32'd0);
    rr15 = 1'b1;
    @(posedge clk);
    #1;
    rr15 = 1'b0;
  endtask

  initial begin
    logic        wr;
    logic [31:0] a;
    reqValid = 0; reqWrite = 0; reqAddr = 0;
    reqWdata = 0; rspReady = 0;
    rv1 = 0; rr1 = 0; rv15 = 0; rr15 = 0;
    clearModel();
    #12;
    check("rst_valid", 32'(rspValid), 32'd0);
    check("rst_rdata", rspRdata, 32'h0);
    check("rst_err", 32'(rspErr), 32'd0);
    check("rst_ready", 32'(reqReady), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    doReq(1'b0, 32'h0000_00FC, 32'h0, 0);
    doReq(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 0);
    doReq(1'b0, 32'h0000_0010, 32'h0, 0);
    doReq(1'b0, 32'h0000_0012, 32'h0, 0);
    doReq(1'b1, 32'h0000_0100, 32'h1111_2222, 1);
    doReq(1'b0, 32'h0000_0100, 32'h0, 0);
    doReq(1'b0, 32'h0000_0010, 32'h0, 5);

    // Reset lands while the store is still in BUSY.
    @(negedge clk);
    reqValid = 1'b1;
    reqWrite = 1'b1;
    reqAddr  = 32'h20;
    reqWdata = 32'h1234_5678;
    @(posedge clk);
    #1;
    reqValid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    clearModel();
    #1;
    check("abort_valid", 32'(rspValid), 32'd0);
    check("abort_ready", 32'(reqReady), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    doReq(1'b0, 32'h0000_0020, 32'h0, 0);
    doReq(1'b0, 32'h0000_0010, 32'h0, 0);

    for (int t = 0; t < 60; t++) begin
      wr = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 9))
        0: a = (32'($urandom_range(0, 63)) << 2)
               | 32'($urandom_range(1, 3));
        1: a = 32'h100 + (32'($urandom_range(0, 4000)) << 2);
        2: a = $urandom | 32'h8000_0000;
        3: a = 32'h0000_00FC;
        default: a = 32'($urandom_range(0, 7)) << 2;
      endcase
      doReq(wr, a, $urandom, $urandom_range(0, 3));
    end

    measure1();
    measure15();

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
